// File: rtl/mmul_parallel_tile_sched_if.sv
// Job/stream handshake bundle for mmul_parallel_tile_sched.
// slave = scheduler side, master = controller/stream side.
interface mmul_parallel_tile_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  clear_i;
    logic                  start_i;
    logic [CNT_WIDTH-1:0]  n_rows_i;
    logic [CNT_WIDTH-1:0]  n_cols_i;
    logic [ADDR_WIDTH-1:0] base_in1_i;
    logic [ADDR_WIDTH-1:0] base_in2_i;
    logic [ADDR_WIDTH-1:0] base_out_i;
    logic [ADDR_WIDTH-1:0] stride_in1_i;
    logic [ADDR_WIDTH-1:0] stride_in2_i;
    logic [ADDR_WIDTH-1:0] stride_out_i;
    logic                  src_done_i;
    logic                  sink_done_i;
    logic                  tile_start_o;
    logic [ADDR_WIDTH-1:0] addr_in1_o;
    logic [ADDR_WIDTH-1:0] addr_in2_o;
    logic [ADDR_WIDTH-1:0] addr_out_o;
    logic [CNT_WIDTH-1:0]  row_o;
    logic [CNT_WIDTH-1:0]  col_o;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  clear_i, start_i, n_rows_i, n_cols_i,
        input  base_in1_i, base_in2_i, base_out_i,
        input  stride_in1_i, stride_in2_i, stride_out_i,
        input  src_done_i, sink_done_i,
        output tile_start_o, addr_in1_o, addr_in2_o, addr_out_o,
        output row_o, col_o, busy_o, done_o
    );

    modport master (
        output clear_i, start_i, n_rows_i, n_cols_i,
        output base_in1_i, base_in2_i, base_out_i,
        output stride_in1_i, stride_in2_i, stride_out_i,
        output src_done_i, sink_done_i,
        input  tile_start_o, addr_in1_o, addr_in2_o, addr_out_o,
        input  row_o, col_o, busy_o, done_o
    );
endinterface

// File: rtl/mmul_parallel_tile_sched.sv
// Row-major tile walker for a matrix-multiply job: launches one tile at a time and advances on both stream dones.
// Optional busy-cycle counter perf_cycles_o is built when MMUL_PARALLEL_TILE_SCHED_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start_i, config inputs sampled on accept
// LAUNCH  | tile_start_o pulse, done latches cleared
// WAIT    | collecting src/sink done pulses
// ADVANCE | step col/row and tile addresses
// DONE    | done_o pulse, back to IDLE
module mmul_parallel_tile_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    mmul_parallel_tile_sched_if.slave bus
`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
    ,
    output logic [31:0] perf_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_WIDTH-1:0]  r_n_rows;
    logic [CNT_WIDTH-1:0]  r_n_cols;
    logic [CNT_WIDTH-1:0]  r_row;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [ADDR_WIDTH-1:0] r_base_in2;
    logic [ADDR_WIDTH-1:0] r_stride_in1;
    logic [ADDR_WIDTH-1:0] r_stride_in2;
    logic [ADDR_WIDTH-1:0] r_stride_out;
    logic [ADDR_WIDTH-1:0] r_addr_in1;
    logic [ADDR_WIDTH-1:0] r_addr_in2;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic                  r_src_seen;
    logic                  r_sink_seen;

    logic w_start_acc;
    logic w_empty_job;
    logic w_both_done;
    logic w_last_col;
    logic w_last_row;

    assign w_start_acc = (r_state == S_IDLE) && bus.start_i && !bus.clear_i;
    assign w_empty_job = (bus.n_rows_i == '0) || (bus.n_cols_i == '0);
    // A pulse arriving this cycle counts as seen, so the last one advances without an extra wait cycle.
    assign w_both_done = (r_src_seen || bus.src_done_i) && (r_sink_seen || bus.sink_done_i);
    assign w_last_col  = (r_col == r_n_cols - CNT_WIDTH'(1));
    assign w_last_row  = (r_row == r_n_rows - CNT_WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.clear_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        w_next = w_empty_job ? S_DONE : S_LAUNCH;
                    end
                end
                S_LAUNCH:  w_next = S_WAIT;
                S_WAIT: begin
                    if (w_both_done) begin
                        w_next = S_ADVANCE;
                    end
                end
                S_ADVANCE: w_next = (w_last_col && w_last_row) ? S_DONE : S_LAUNCH;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.tile_start_o = 1'b0;
        bus.busy_o       = 1'b1;
        bus.done_o       = 1'b0;
        unique case (r_state)
            S_IDLE:   bus.busy_o       = 1'b0;
            S_LAUNCH: bus.tile_start_o = 1'b1;
            S_DONE:   bus.done_o       = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n_rows     <= '0;
            r_n_cols     <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_base_in2   <= '0;
            r_stride_in1 <= '0;
            r_stride_in2 <= '0;
            r_stride_out <= '0;
            r_addr_in1   <= '0;
            r_addr_in2   <= '0;
            r_addr_out   <= '0;
            r_src_seen   <= 1'b0;
            r_sink_seen  <= 1'b0;
        end else if (bus.clear_i) begin
            r_src_seen  <= 1'b0;
            r_sink_seen <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_n_rows     <= bus.n_rows_i;
                        r_n_cols     <= bus.n_cols_i;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_base_in2   <= bus.base_in2_i;
                        r_stride_in1 <= bus.stride_in1_i;
                        r_stride_in2 <= bus.stride_in2_i;
                        r_stride_out <= bus.stride_out_i;
                        r_addr_in1   <= bus.base_in1_i;
                        r_addr_in2   <= bus.base_in2_i;
                        r_addr_out   <= bus.base_out_i;
                        r_src_seen   <= 1'b0;
                        r_sink_seen  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_src_seen  <= 1'b0;
                    r_sink_seen <= 1'b0;
                end
                S_WAIT: begin
                    if (bus.src_done_i) begin
                        r_src_seen <= 1'b1;
                    end
                    if (bus.sink_done_i) begin
                        r_sink_seen <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    if (!w_last_col) begin
                        r_col      <= r_col + CNT_WIDTH'(1);
                        r_addr_in2 <= r_addr_in2 + r_stride_in2;
                        r_addr_out <= r_addr_out + r_stride_out;
                    end else if (!w_last_row) begin
                        r_col      <= '0;
                        r_row      <= r_row + CNT_WIDTH'(1);
                        r_addr_in1 <= r_addr_in1 + r_stride_in1;
                        r_addr_in2 <= r_base_in2;
                        r_addr_out <= r_addr_out + r_stride_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr_in1_o = r_addr_in1;
    assign bus.addr_in2_o = r_addr_in2;
    assign bus.addr_out_o = r_addr_out;
    assign bus.row_o      = r_row;
    assign bus.col_o      = r_col;

`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_cycles <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
        end else if (bus.busy_o && (r_perf_cycles != '1)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf_cycles;
`endif

endmodule

// File: tb/tb_mmul_parallel_tile_sched.sv
// Directed bench for mmul_parallel_tile_sched: expected tiles are queued from an index-based address model
// when a job is started and popped by a monitor on every tile_start_o.
module tb_mmul_parallel_tile_sched;
    localparam int AW = 32;
    localparam int CW = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    mmul_parallel_tile_sched_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    mmul_parallel_tile_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o)
`endif
    );

    typedef struct {
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] ao;
    } tile_t;

    tile_t exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int tile_cnt  = 0;
    int done_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples at +1 after the edge; the stimulus thread works at +2 so it sees updated counts.
    always @(posedge clk_i) begin : mon
        tile_t e;
        #1;
        if (bus.done_o === 1'b1) done_cnt++;
        if (bus.tile_start_o === 1'b1) begin
            tile_cnt++;
            chk("tile_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tile_row",      bus.row_o,      e.row);
                chk("tile_col",      bus.col_o,      e.col);
                chk("tile_addr_in1", bus.addr_in1_o, e.a1);
                chk("tile_addr_in2", bus.addr_in2_o, e.a2);
                chk("tile_addr_out", bus.addr_out_o, e.ao);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_tile(input int r, input int c, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] ao);
        tile_t t;
        t.row = CW'(r);
        t.col = CW'(c);
        t.a1  = a1;
        t.a2  = a2;
        t.ao  = ao;
        exp_q.push_back(t);
    endtask

    task automatic push_job(input int rows, input int cols,
                            input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [AW-1:0] bo,
                            input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] so);
        logic [AW-1:0] a1, a2, ao;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                a1 = b1 + s1 * AW'(r);
                a2 = b2 + s2 * AW'(c);
                ao = bo + so * AW'(r * cols + c);
                push_tile(r, c, a1, a2, ao);
            end
        end
    endtask

    task automatic set_cfg(input int rows, input int cols,
                           input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [AW-1:0] bo,
                           input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] so);
        bus.n_rows_i     = CW'(rows);
        bus.n_cols_i     = CW'(cols);
        bus.base_in1_i   = b1;
        bus.base_in2_i   = b2;
        bus.base_out_i   = bo;
        bus.stride_in1_i = s1;
        bus.stride_in2_i = s2;
        bus.stride_out_i = so;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    // Responds to each tile_start_o with done pulses d cycles later (first tile uses ds0/dk0, rest ds1/dk1).
    task automatic run_job(input string tag, input int ds0, input int dk0, input int ds1, input int dk1,
                           input bit poke);
        int cs, ck, cyc, last, ntile, d0;
        bit got;
        cs = 0; ck = 0; cyc = 0; last = -100; ntile = 0; d0 = done_cnt; got = 1'b0;
        while (!got && cyc < 400) begin
            bus.src_done_i  = 1'b0;
            bus.sink_done_i = 1'b0;
            bus.start_i     = 1'b0;
            if (bus.done_o === 1'b1) begin
                got = 1'b1;
                if (ntile > 0) chk({tag, "_done_gap"}, 64'(cyc - last), 2);
            end else begin
                if (bus.tile_start_o === 1'b1) begin
                    chk({tag, "_busy"}, bus.busy_o, 1);
                    if (ntile > 0) chk({tag, "_tile_gap"}, 64'(cyc - last), 2);
                    cs = (ntile == 0) ? ds0 : ds1;
                    ck = (ntile == 0) ? dk0 : dk1;
                    ntile++;
                end
                if (cs > 0) begin
                    if (cs == 1) begin
                        bus.src_done_i = 1'b1;
                        last = cyc;
                    end
                    cs--;
                end
                if (ck > 0) begin
                    if (ck == 1) begin
                        bus.sink_done_i = 1'b1;
                        last = cyc;
                    end
                    ck--;
                end
                if (poke && (cs > 0 || ck > 0)) bus.start_i = 1'b1;
                step();
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 1);
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 1);
        bus.src_done_i  = 1'b0;
        bus.sink_done_i = 1'b0;
        bus.start_i     = 1'b0;
        step();
        chk({tag, "_idle_after"}, {bus.busy_o, bus.done_o}, 0);
    endtask

    task automatic full_job(input string tag, input int rows, input int cols,
                            input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [AW-1:0] bo,
                            input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] so,
                            input int ds0, input int dk0, input int ds1, input int dk1, input bit poke);
        int t0;
        t0 = tile_cnt;
        push_job(rows, cols, b1, b2, bo, s1, s2, so);
        set_cfg(rows, cols, b1, b2, bo, s1, s2, so);
        pulse_start();
        if (poke) begin
            // Config changes while busy must not reach the running job.
            set_cfg(7, 7, 32'hDEAD_0000, 32'hBEEF_0000, 32'hCAFE_0000, 32'h4, 32'h4, 32'h4);
        end
        run_job(tag, ds0, dk0, ds1, dk1, poke);
        chk({tag, "_tiles"}, 64'(tile_cnt - t0), 64'(rows * cols));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
    endtask

    initial begin : stim
        int t0, d0;
        bus.clear_i     = 1'b0;
        bus.start_i     = 1'b0;
        bus.src_done_i  = 1'b0;
        bus.sink_done_i = 1'b0;
        set_cfg(0, 0, '0, '0, '0, '0, '0, '0);

        #1 rst_ni = 1'b0;
        step();
        step();
        chk("rst_ctrl", {bus.tile_start_o, bus.busy_o, bus.done_o}, 0);
        chk("rst_addr", {bus.addr_in1_o, bus.addr_in2_o}, 0);
        chk("rst_addr_out_idx", {bus.addr_out_o, bus.row_o, bus.col_o}, 0);
`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
        chk("rst_perf", perf_cycles_o, 0);
`endif
        rst_ni = 1'b1;
        step();

        // Main 2x3 walk.
        full_job("job2x3", 2, 3, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h80, 32'h10, 5, 5, 5, 5, 1'b0);

        // Empty job: straight to DONE.
        t0 = tile_cnt;
        set_cfg(0, 4, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h80, 32'h10);
        pulse_start();
        chk("empty_first", {bus.busy_o, bus.done_o, bus.tile_start_o}, 3'b110);
        step();
        chk("empty_second", {bus.busy_o, bus.done_o, bus.tile_start_o}, 3'b000);
        chk("empty_no_tiles", 64'(tile_cnt - t0), 0);

        // Stray dones in IDLE.
        bus.src_done_i  = 1'b1;
        bus.sink_done_i = 1'b1;
        step();
        bus.src_done_i  = 1'b0;
        bus.sink_done_i = 1'b0;
        chk("stray_idle", {bus.busy_o, bus.done_o, bus.tile_start_o}, 0);

        // Sink before src, then both together; start pulses while busy.
        full_job("order", 1, 2, 32'h100, 32'h200, 32'h300, 32'h8, 32'h10, 32'h20, 4, 2, 3, 3, 1'b1);

        // clear has priority over start in IDLE.
        set_cfg(1, 1, '0, '0, '0, '0, '0, '0);
        bus.clear_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        bus.start_i = 1'b0;
        chk("clear_over_start", {bus.busy_o, bus.tile_start_o}, 0);

        // Abort in WAIT of the second tile together with a src done.
        t0 = tile_cnt;
        d0 = done_cnt;
        push_tile(0, 0, 32'h5000, 32'h6000, 32'h7000);
        push_tile(0, 1, 32'h5000, 32'h6100, 32'h7004);
        set_cfg(1, 3, 32'h5000, 32'h6000, 32'h7000, 32'h1, 32'h100, 32'h4);
        pulse_start();
        step();
        bus.src_done_i  = 1'b1;
        bus.sink_done_i = 1'b1;
        step();
        bus.src_done_i  = 1'b0;
        bus.sink_done_i = 1'b0;
        step();
        chk("abort_tile2_launch", bus.tile_start_o, 1);
        step();
        bus.src_done_i = 1'b1;
        bus.clear_i    = 1'b1;
        step();
        bus.src_done_i = 1'b0;
        bus.clear_i    = 1'b0;
        chk("abort_idle", {bus.busy_o, bus.tile_start_o, bus.done_o}, 0);
        repeat (4) step();
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        chk("abort_tiles", 64'(tile_cnt - t0), 2);
        chk("abort_queue_empty", 64'(exp_q.size()), 0);

        full_job("after_abort", 2, 2, 32'h10, 32'h20, 32'h30, 32'h100, 32'h200, 32'h300, 3, 2, 2, 6, 1'b0);

        // Address wrap on the output stream.
        full_job("wrap", 1, 2, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 3, 3, 3, 3, 1'b0);

        // Asynchronous reset mid-job.
        t0 = tile_cnt;
        d0 = done_cnt;
        push_tile(0, 0, 32'hA000, 32'hB000, 32'hC000);
        set_cfg(3, 3, 32'hA000, 32'hB000, 32'hC000, 32'h10, 32'h10, 32'h10);
        pulse_start();
        step();
        step();
        chk("midjob_busy", bus.busy_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_ctrl", {bus.tile_start_o, bus.busy_o, bus.done_o}, 0);
        chk("arst_addr", {bus.addr_in1_o, bus.addr_in2_o}, 0);
        chk("arst_addr_out_idx", {bus.addr_out_o, bus.row_o, bus.col_o}, 0);
        step();
        #3 rst_ni = 1'b1;
        repeat (5) step();
        chk("arst_no_done", 64'(done_cnt - d0), 0);
        chk("arst_tiles", 64'(tile_cnt - t0), 1);
        chk("arst_idle", bus.busy_o, 0);
        chk("arst_queue_empty", 64'(exp_q.size()), 0);

`ifdef MMUL_PARALLEL_TILE_SCHED_PERF_EN
        // One tile with dones 3 cycles after launch: LAUNCH, WAIT x2, ADVANCE, DONE.
        full_job("perf", 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3, 3, 3, 3, 1'b0);
        chk("perf_count", perf_cycles_o, 5);
        repeat (3) step();
        chk("perf_held", perf_cycles_o, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
